// File: rtl/nco_pkg.sv
// ---------------------------------------------------------------------------
// nco_pkg
// Shared definitions for the NCO and its PWM DAC consumer.
//   OW_DEFAULT  : default sample width, shared by the NCO output and the DAC
//   pwm_state_t : PWM DAC control state (IDLE, RUN, DRAIN)
//   all_ones    : helper returning an OW-wide all-ones value (last count)
// ---------------------------------------------------------------------------
package nco_pkg;

    localparam int OW_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

    // Terminal count of a w-bit counter, returned in a 32-bit container
    function automatic logic [31:0] all_ones(input int w);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < w; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// ---------------------------------------------------------------------------
// pwm_tick_gen
// Prescaler producing one PWM tick every DIV clocks while enabled.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_en    : run enable; when low the prescaler is held at zero
//   o_tick  : high in the clock where the prescaler sits at DIV-1
// ---------------------------------------------------------------------------
module pwm_tick_gen #(
    parameter int DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int          DW       = $clog2(DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_r;

    // Prescaler counter: 0..DIV-1 while enabled, cleared otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_r <= {DW{1'b0}};
        end else if (!i_en) begin
            div_r <= {DW{1'b0}};
        end else if (div_r == DIV_LAST) begin
            div_r <= {DW{1'b0}};
        end else begin
            div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    // Gate with enable so DIV=1 does not tick while idle
    assign o_tick = i_en && (div_r == DIV_LAST);

endmodule

// File: rtl/pwm_dac.sv
// ---------------------------------------------------------------------------
// pwm_dac
// Converts an OW-bit unsigned NCO sample into a single-bit PWM stream and
// acts as the sample-rate master for the NCO.
//   i_clk   : system clock (posedge)
//   i_rst_n : asynchronous active-low reset
//   i_en    : run request, level sensitive
//   i_val   : NCO sample, latched only at period start
//   o_ce    : one-clock strobe per period start (drives NCO i_ce)
//   o_sync  : one-clock period-start marker, coincident with o_ce
//   o_pwm   : registered PWM output
//   o_busy  : high whenever the block is not idle
// Period = 2^OW * DIV clocks; high time = latched duty * DIV clocks.
// ---------------------------------------------------------------------------
module pwm_dac
    import nco_pkg::*;
#(
    parameter int OW  = OW_DEFAULT,
    parameter int DIV = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [OW-1:0] i_val,
    output logic          o_ce,
    output logic          o_sync,
    output logic          o_pwm,
    output logic          o_busy
);

    localparam logic [OW-1:0] CNT_MAX = OW'(all_ones(OW));

    pwm_state_t    state_r, state_n;
    logic [OW-1:0] cnt_r, cnt_n;
    logic [OW-1:0] duty_r, duty_n;
    logic          ce_r, ce_n;
    logic          sync_r;
    logic          pwm_r;
    logic          busy_r;
    logic          tick_s;
    logic          boundary_s;
    logic          active_s;

    assign active_s = (state_r != IDLE);

    pwm_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (active_s),
        .o_tick  (tick_s)
    );

    assign boundary_s = tick_s && (cnt_r == CNT_MAX);

    // Next-state, counter, duty latch and strobe decode
    always_comb begin
        state_n = state_r;
        duty_n  = duty_r;
        ce_n    = 1'b0;
        cnt_n   = tick_s ? (cnt_r + OW'(1)) : cnt_r;

        case (state_r)
            IDLE: begin
                if (i_en) begin
                    state_n = RUN;
                    cnt_n   = {OW{1'b0}};
                    duty_n  = i_val;
                    ce_n    = 1'b1;
                end else begin
                    state_n = IDLE;
                    cnt_n   = {OW{1'b0}};
                end
            end
            RUN, DRAIN: begin
                if (boundary_s) begin
                    // Counter wraps to 0 here; i_en at the boundary decides
                    // whether a new period starts or the block parks.
                    if (i_en) begin
                        state_n = RUN;
                        duty_n  = i_val;
                        ce_n    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (i_en) begin
                        state_n = RUN;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = {OW{1'b0}};
            end
        endcase
    end

    // State, counter, latch and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {OW{1'b0}};
            duty_r  <= {OW{1'b0}};
            ce_r    <= 1'b0;
            sync_r  <= 1'b0;
            pwm_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            duty_r  <= duty_n;
            ce_r    <= ce_n;
            sync_r  <= ce_n;
            // Compare uses current registers, so o_pwm lags cnt_r by a clock
            pwm_r   <= active_s && (cnt_r < duty_r);
            busy_r  <= (state_n != IDLE);
        end
    end

    assign o_ce   = ce_r;
    assign o_sync = sync_r;
    assign o_pwm  = pwm_r;
    assign o_busy = busy_r;

endmodule

// File: tb/tb_pwm_dac.sv
// ---------------------------------------------------------------------------
// tb_pwm_dac
// Randomized bench for pwm_dac with DIV=1 and DIV=3 instances driven by the
// same inputs. A period-level reference model (phase within period, latched
// duty, active flag) predicts every output each clock.
// ---------------------------------------------------------------------------
module tb_pwm_dac;

    localparam int OW = 7;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [OW-1:0] val;

    logic ce1, sync1, pwm1, busy1;
    logic ce3, sync3, pwm3, busy3;

    int n_checks;
    int n_errors;
    int cyc;

    // Reference model state, index 0 -> DIV=1, index 1 -> DIV=3
    int m_div   [2];
    int m_per   [2];
    bit m_act   [2];
    int m_t     [2];
    int m_duty  [2];
    bit m_ce    [2];
    bit m_pwm   [2];
    int last_ce [2];
    bit gap_ok  [2];

    pwm_dac #(.OW(OW), .DIV(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_val   (val),
        .o_ce    (ce1),
        .o_sync  (sync1),
        .o_pwm   (pwm1),
        .o_busy  (busy1)
    );

    pwm_dac #(.OW(OW), .DIV(3)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_val   (val),
        .o_ce    (ce3),
        .o_sync  (sync3),
        .o_pwm   (pwm3),
        .o_busy  (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 1'b0;
            m_t[i]    = 0;
            m_duty[i] = 0;
            m_ce[i]   = 1'b0;
            m_pwm[i]  = 1'b0;
            gap_ok[i] = 1'b0;
        end
    endtask

    // One clock edge of the period-level model: t is clocks since period start
    task automatic model_edge(input int i);
        if (!rst_n) begin
            m_act[i] = 1'b0; m_t[i] = 0; m_duty[i] = 0;
            m_ce[i] = 1'b0;  m_pwm[i] = 1'b0;
        end else if (!m_act[i]) begin
            m_pwm[i] = 1'b0;
            m_ce[i]  = en;
            if (en) begin
                m_act[i] = 1'b1; m_t[i] = 0; m_duty[i] = int'(val);
            end
        end else begin
            m_pwm[i] = ((m_t[i] / m_div[i]) < m_duty[i]);
            m_ce[i]  = 1'b0;
            if (m_t[i] == m_per[i] - 1) begin
                if (en) begin
                    m_t[i] = 0; m_duty[i] = int'(val); m_ce[i] = 1'b1;
                end else begin
                    m_act[i] = 1'b0;
                end
            end else begin
                m_t[i] = m_t[i] + 1;
            end
        end
    endtask

    task automatic check_inst(input int i, input logic ce, input logic sync,
                              input logic pwm, input logic busy);
        string s;
        s = (i == 0) ? "d1" : "d3";
        check_eq({s, "_ce"},   int'(ce),   int'(m_ce[i]));
        check_eq({s, "_sync"}, int'(sync), int'(m_ce[i]));
        check_eq({s, "_pwm"},  int'(pwm),  int'(m_pwm[i]));
        check_eq({s, "_busy"}, int'(busy), int'(m_act[i]));
        // Strobe spacing across uninterrupted periods
        if (ce === 1'b1) begin
            if (gap_ok[i]) begin
                check_eq({s, "_ce_gap"}, cyc - last_ce[i], m_per[i]);
            end
            last_ce[i] = cyc;
            gap_ok[i]  = 1'b1;
        end
        if (!m_act[i]) begin
            gap_ok[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check_inst(0, ce1, sync1, pwm1, busy1);
        check_inst(1, ce3, sync3, pwm3, busy3);
    endtask

    task automatic check_all_low(input string tag);
        check_eq({tag, "_d1_pwm"},  int'(pwm1),  0);
        check_eq({tag, "_d1_busy"}, int'(busy1), 0);
        check_eq({tag, "_d1_ce"},   int'(ce1),   0);
        check_eq({tag, "_d1_sync"}, int'(sync1), 0);
        check_eq({tag, "_d3_pwm"},  int'(pwm3),  0);
        check_eq({tag, "_d3_busy"}, int'(busy3), 0);
        check_eq({tag, "_d3_ce"},   int'(ce3),   0);
        check_eq({tag, "_d3_sync"}, int'(sync3), 0);
    endtask

    initial begin
        int r;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_div[0] = 1;  m_per[0] = (1 << OW) * 1;
        m_div[1] = 3;  m_per[1] = (1 << OW) * 3;
        model_reset();
        last_ce[0] = 0;
        last_ce[1] = 0;

        rst_n = 1'b0;
        en    = 1'b0;
        val   = '0;
        #2;
        check_all_low("reset");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Run at half duty, then reset asynchronously mid-period
        val = 7'd64;
        en  = 1'b1;
        repeat (50) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_low("async_rst");
        model_reset();
        en = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();

        // Duty extremes
        val = 7'd0;
        en  = 1'b1;
        repeat (3 * 384 + 10) step();
        val = 7'd127;
        repeat (800) step();

        // Random sample changes and enable drops/reasserts
        repeat (6000) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                en = ~en;
            end
            if (r >= 70) begin
                val = 7'($urandom);
            end
            step();
        end

        // Drain to idle and confirm no trailing strobe
        en = 1'b0;
        repeat (400) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
